// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: size/state encodings, stall constants and request record for the data-memory access path.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Size 3 is treated as a word everywhere, so size[1] means "word".
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_HALF && a[0]) || (size[1] && a != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_mem_align.sv
// mem_align: store strobe/data replication and load byte-lane extraction with sign/zero extension.
module mem_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_ext
);

    logic [31:0] sh;

    assign sh = rdata >> {offset, 3'b000};

    always_comb begin
        wstrb     = !we ? 4'b0000 : size[1] ? 4'b1111 : (size == SZ_HALF ? 4'b0011 : 4'b0001) << offset;
        wdata_rep = size[1] ? wdata : size[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        ld_ext    = size[1] ? sh
                  : size[0] ? {{16{sgn & sh[15]}}, sh[15:0]}
                  : {{24{sgn & sh[7]}}, sh[7:0]};
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences EX/MEM loads and stores onto a split req/addr_ok/data_ok SRAM bus.
// Stalls the pipeline while an access is outstanding; flags misalignment and bus timeouts.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stallreq,
    output logic        resp_valid,
    output logic [31:0] ld_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_t           state, state_nxt;
    mem_req_t         r;
    logic             cancel;
    logic [CNT_W-1:0] cnt;
    logic             mis, start, busy, timeout, cancel_now;
    logic [3:0]       strb;
    logic [31:0]      wrep, ld_ext;

    assign mis        = misaligned(req_size, req_addr[1:0]);
    assign start      = state == IDLE && req_valid && !mis && !flush;
    assign busy       = state == ADDR || state == DATA;
    assign timeout    = busy && cnt == CNT_W'(TIMEOUT - 1);
    // A flush landing on the completing cycle discards the result just like an earlier one.
    assign cancel_now = cancel | flush;

    mem_align u_align (
        .we        (r.we),
        .size      (r.size),
        .sgn       (r.sgn),
        .offset    (r.addr[1:0]),
        .wdata     (r.wdata),
        .rdata     (data_rdata),
        .wstrb     (strb),
        .wdata_rep (wrep),
        .ld_ext    (ld_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? ADDR : IDLE;
            ADDR:    state_nxt = timeout ? IDLE : !data_addr_ok ? ADDR : !data_data_ok ? DATA
                               : cancel_now ? IDLE : DONE;
            DATA:    state_nxt = timeout || (data_data_ok && cancel_now) ? IDLE
                               : data_data_ok ? DONE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_req   = state == ADDR;
        data_wr    = data_req & r.we;
        data_size  = data_req ? (r.size[1] ? SZ_WORD : r.size) : 2'b00;
        data_addr  = data_req ? r.addr : '0;
        data_wstrb = data_req ? strb : '0;
        data_wdata = data_req ? wrep : '0;
        stallreq   = start || busy ? Stop : NoStop;
        resp_valid = state == DONE && !flush;
        addr_err   = req_valid & mis;
        bus_err    = timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r       <= '0;
            cancel  <= 1'b0;
            cnt     <= '0;
            ld_data <= '0;
        end else begin
            if (start) r <= '{we: req_we, size: req_size, sgn: req_signed, addr: req_addr, wdata: req_wdata};
            cancel <= state_nxt == IDLE ? 1'b0 : cancel | (busy & flush);
            cnt    <= busy && (state_nxt == ADDR || state_nxt == DATA) ? cnt + 1'b1 : '0;
            if (state_nxt == DONE && !r.we) ld_data <= ld_ext;
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every load/store from the EX/MEM boundary onto a split-handshake data SRAM bus (req / addr_ok / data_ok).
- Generates byte strobes and replicated write data; aligns and sign/zero-extends load data.
- Raises a stall request into the pipeline stall controller while an access is outstanding.
- Flags misaligned accesses and bus timeouts; never leaves a transaction half-finished on the bus.

Parameters:
TIMEOUT, 64, max cycles in ADDR+DATA before the bus_err pulse (≥2)
CNT_W, 7, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock; all flops rising-edge
rst  in  1  asynchronous active-low reset (0 = reset)
req_valid  in  1  EX holds a memory instruction this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word (3 = word)
req_signed  in  1  sign-extend load result
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
flush  in  1  pipeline flush; cancels the current instruction
stallreq  out  1  hold the pipeline at EX and earlier
resp_valid  out  1  one-cycle pulse; ld_data valid (loads) / store done
ld_data  out  32  aligned, extended load data
addr_err  out  1  misaligned access, same cycle as req_valid, no bus request
bus_err  out  1  one-cycle pulse on timeout
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size (0/1/2)
data_addr  out  32  bus address, low bits as given
data_wstrb  out  4  byte strobes
data_wdata  out  32  replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data / write ack returned
data_rdata  in  32  read data

Behaviour:
- Reset (rst=0, async): state IDLE, cancel=0, counter=0, latched request/result regs=0. All outputs 0.
- States: IDLE, ADDR, DATA, DONE.
- Misaligned: half with addr[0]≠0, or word with addr[1:0]≠0.
  - addr_err = req_valid & misaligned (combinational).
  - No bus request; stay in IDLE; stallreq=0.
- IDLE:
  - On req_valid & ~misaligned & ~flush: latch request, go to ADDR.
  - stallreq is asserted combinationally in that same cycle.
  - A flush in IDLE starts nothing.
- ADDR:
  - data_req=1; data_* driven from the latched regs, held stable until addr_ok.
  - On data_addr_ok: go to DATA.
  - data_addr_ok and data_data_ok in the same cycle: go straight to DONE, latching rdata.
- DATA:
  - data_req=0.
  - On data_data_ok: latch the extended rdata into ld_data and go to DONE.
  - If cancel=1, go to IDLE instead and do not update ld_data.
- DONE:
  - resp_valid=1, stallreq=0 for exactly one cycle, then IDLE.
  - The pipeline advances at the end of this cycle; the same instruction is never re-issued.
- stallreq:
  - (IDLE & req_valid & ~misaligned & ~flush) | ADDR | DATA.
  - Stays 1 while cancel=1 so no new request starts until the bus drains.
- flush:
  - In ADDR or DATA, sets cancel; the handshake still completes and the result is discarded (resp_valid=0).
  - In DONE, suppresses resp_valid.
  - cancel clears on return to IDLE.
- Timeout:
  - The counter increments in ADDR/DATA and clears elsewhere.
  - Reaching TIMEOUT−1 pulses bus_err and forces IDLE (data_req drops, cancel clears).
- Strobes (a = addr[1:0]):
  - byte: 4'b0001<<a
  - half: 4'b0011<<a
  - word: 4'b1111
  - loads: 4'b0000
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction: byte = rdata[8a+7:8a], half = rdata[8a+15:8a]; extend per req_signed.
- Async reset mid-access: return to IDLE immediately. The external bus is reset by the same rst.

Decomposition:
- Shared defines file: size encodings (SZ_BYTE/HALF/WORD) and state encodings.
- Reuse the existing `Stop`/`NoStop` constants for stallreq.
- One sub-module, mem_align: combinational strobe/wdata replication and load extract/extend, reused by the WB-side and any future uncached path.

Test Plan:
- Aligned word load, addr 0x1000_0004; addr_ok after 2 cycles, data_ok 1 later with 0xDEAD_BEEF → data_req high 3 cycles; stallreq high until DONE; resp_valid one cycle, ld_data=0xDEAD_BEEF.
- Signed byte load at 0x...03, rdata 0x80FF_1234 → ld_data=0xFFFF_FF80; unsigned → 0x0000_0080.
- Half store at 0x...02, wdata 0x0000_ABCD → data_wstrb=4'b1100, data_wdata=0xABCD_ABCD, data_wr=1.
- Word load at 0x...02 → addr_err=1 same cycle, data_req never asserts, stallreq=0.
- Flush asserted in DATA → stallreq held until data_ok, resp_valid stays 0, ld_data unchanged, next request issues the following cycle.
- addr_ok never returns with TIMEOUT=8 → bus_err pulses on cycle 8 of the access, data_req drops, state returns to IDLE; rst=0 mid-ADDR clears all outputs asynchronously.
